// File: rtl/ldiv_round_buf.sv
// ldiv_round_buf: post-processor and elastic buffer for the pipelined long divider.
// Each incoming quotient is rounded (half away from zero) when LDIV_ROUND_EN is
// defined, or kept truncated when it is not. It is then saturated to OUT_WIDTH
// and pushed into a show-ahead FIFO. The divider cannot stall, so results that
// arrive while the FIFO is full are dropped and counted.
module ldiv_round_buf #(
  parameter int NUMERATOR_WIDTH   = 10,
  parameter int DENOMINATOR_WIDTH = 10,
  parameter int QUOTIENT_WIDTH    = 10,
  parameter int OUT_WIDTH         = 8,
  parameter int DEPTH             = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [QUOTIENT_WIDTH-1:0]    quotient_in,
  input  logic [NUMERATOR_WIDTH-1:0]   remainder_in,
  input  logic [DENOMINATOR_WIDTH-1:0] denominator_in,
  input  logic                         valid_in,
  output logic [OUT_WIDTH-1:0]         out_quotient,
  output logic                         out_sat,
  output logic                         out_div0,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         overflow,
  output logic [15:0]                  drop_count
);

  localparam int NW = NUMERATOR_WIDTH;
  localparam int DW = DENOMINATOR_WIDTH;
  localparam int QW = QUOTIENT_WIDTH;
  localparam int OW = OUT_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int EW = OW + 2;

  // Clamp limits expressed in the widened quotient domain; SAT_MIN is the
  // bitwise complement of SAT_MAX, i.e. -2^(OW-1).
  localparam logic signed [QW:0] SAT_MAX = $signed((QW+1)'((1 << (OW - 1)) - 1));
  localparam logic signed [QW:0] SAT_MIN = ~SAT_MAX;

  localparam logic [OW-1:0] OUT_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] OUT_MIN = {1'b1, {(OW-1){1'b0}}};

  logic signed [QW:0] qExt;
  logic signed [QW:0] qRnd;
  logic [OW-1:0]      s1Quot_d;
  logic               s1Sat_d;
  logic               s1Div0_d;

  logic               s1Valid_q;
  logic [OW-1:0]      s1Quot_q;
  logic               s1Sat_q;
  logic               s1Div0_q;

  logic [EW-1:0]      mem_q [DEPTH];
  logic [AW:0]        wrPtr_q;
  logic [AW:0]        rdPtr_q;
  logic               overflow_q;
  logic [15:0]        dropCount_q;

  logic               fifoEmpty;
  logic               fifoFull;
  logic               doPop;
  logic               doPush;
  logic               doDrop;
  logic [EW-1:0]      headEntry;

`ifdef LDIV_ROUND_EN
  localparam int MW = ((NW > DW) ? NW : DW) + 1;

  logic signed [MW-1:0] remExt;
  logic [MW-1:0]        remMag;
  logic [MW:0]          twoMag;
  logic [MW:0]          denExt;

  // Round half away from zero: step the truncated quotient one unit in the
  // sign direction of the remainder when twice the remainder magnitude
  // reaches the denominator.
  always_comb begin
    qExt   = {quotient_in[QW-1], quotient_in};
    remExt = {{(MW-NW){remainder_in[NW-1]}}, remainder_in};
    remMag = remainder_in[NW-1] ? (-remExt) : remExt;
    twoMag = {remMag, 1'b0};
    denExt = {{(MW+1-DW){1'b0}}, denominator_in};
    qRnd   = qExt;
    if (twoMag >= denExt) begin
      if (remainder_in[NW-1]) begin
        qRnd = qExt - (QW+1)'(1);
      end else begin
        qRnd = qExt + (QW+1)'(1);
      end
    end
  end
`else
  logic unusedRemBits;

  assign unusedRemBits = ^remainder_in[NW-2:0];

  // Truncation build: the divider quotient passes straight through.
  always_comb begin
    qExt = {quotient_in[QW-1], quotient_in};
    qRnd = qExt;
  end
`endif

  // Saturate to the output width; a zero denominator bypasses rounding and
  // reports the extreme value matching the remainder sign.
  always_comb begin
    s1Quot_d = qRnd[OW-1:0];
    s1Sat_d  = 1'b0;
    s1Div0_d = 1'b0;
    if (denominator_in == '0) begin
      s1Quot_d = remainder_in[NW-1] ? OUT_MIN : OUT_MAX;
      s1Sat_d  = 1'b1;
      s1Div0_d = 1'b1;
    end else if (qRnd > SAT_MAX) begin
      s1Quot_d = OUT_MAX;
      s1Sat_d  = 1'b1;
    end else if (qRnd < SAT_MIN) begin
      s1Quot_d = OUT_MIN;
      s1Sat_d  = 1'b1;
    end
  end

  // Stage S1 captures the processed result whenever the divider presents one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1Valid_q <= 1'b0;
      s1Quot_q  <= '0;
      s1Sat_q   <= 1'b0;
      s1Div0_q  <= 1'b0;
    end else begin
      s1Valid_q <= valid_in;
      if (valid_in) begin
        s1Quot_q <= s1Quot_d;
        s1Sat_q  <= s1Sat_d;
        s1Div0_q <= s1Div0_d;
      end
    end
  end

  // Full/empty from the extra pointer MSB; a pop frees a slot for a push
  // arriving in the same cycle, so a full FIFO still accepts while draining.
  always_comb begin
    fifoEmpty = (wrPtr_q == rdPtr_q);
    fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    doPop     = !fifoEmpty && out_ready;
    doPush    = s1Valid_q && (!fifoFull || doPop);
    doDrop    = s1Valid_q && !doPush;
  end

  // Storage array holds {quotient, sat, div0}; it needs no reset because
  // the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q[AW-1:0]] <= {s1Quot_q, s1Sat_q, s1Div0_q};
    end
  end

  // Pointer and drop bookkeeping; drop_count holds at its ceiling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      overflow_q  <= 1'b0;
      dropCount_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + (AW+1)'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + (AW+1)'(1);
      end
      if (doDrop) begin
        overflow_q <= 1'b1;
        if (dropCount_q != 16'hFFFF) begin
          dropCount_q <= dropCount_q + 16'd1;
        end
      end
    end
  end

  // Show-ahead head, forced to zero while empty so reset and idle look clean.
  always_comb begin
    headEntry    = fifoEmpty ? '0 : mem_q[rdPtr_q[AW-1:0]];
    out_quotient = headEntry[EW-1:2];
    out_sat      = headEntry[1];
    out_div0     = headEntry[0];
    out_valid    = !fifoEmpty;
    level        = wrPtr_q - rdPtr_q;
    overflow     = overflow_q;
    drop_count   = dropCount_q;
  end

endmodule

// File: tb/tb_ldiv_round_buf.sv
// tb_ldiv_round_buf: directed checks of rounding, saturation, div0, overflow,
// full-FIFO streaming and mid-stream reset for ldiv_round_buf. Expected
// quotients follow LDIV_ROUND_EN so either build can be checked.
module tb_ldiv_round_buf;

  localparam int NW    = 10;
  localparam int DW    = 10;
  localparam int QW    = 10;
  localparam int OW    = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [QW-1:0] quotient_in;
  logic [NW-1:0] remainder_in;
  logic [DW-1:0] denominator_in;
  logic          valid_in;
  logic [OW-1:0] out_quotient;
  logic          out_sat;
  logic          out_div0;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    level;
  logic          overflow;
  logic [15:0]   drop_count;

  int testsRun    = 0;
  int testsFailed = 0;

  ldiv_round_buf #(
    .NUMERATOR_WIDTH  (NW),
    .DENOMINATOR_WIDTH(DW),
    .QUOTIENT_WIDTH   (QW),
    .OUT_WIDTH        (OW),
    .DEPTH            (DEPTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .quotient_in   (quotient_in),
    .remainder_in  (remainder_in),
    .denominator_in(denominator_in),
    .valid_in      (valid_in),
    .out_quotient  (out_quotient),
    .out_sat       (out_sat),
    .out_div0      (out_div0),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .level         (level),
    .overflow      (overflow),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  // One comparison: count it, and report tag/observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one divider result for a single cycle starting at a falling edge.
  task automatic applyStimulus(input logic [QW-1:0] q, input logic [NW-1:0] r, input logic [DW-1:0] d);
    @(negedge clk);
    quotient_in    = q;
    remainder_in   = r;
    denominator_in = d;
    valid_in       = 1'b1;
  endtask

  // Push one vector into an empty FIFO, check latency and head, then pop it.
  task automatic checkVector(input string tag, input logic [QW-1:0] q, input logic [NW-1:0] r,
                             input logic [DW-1:0] d, input logic [OW-1:0] expQ,
                             input logic expSat, input logic expDiv0);
    applyStimulus(q, r, d);
    @(negedge clk);
    valid_in = 1'b0;
    checkOutput({tag, " latency"}, 16'(out_valid), 16'd0);
    @(negedge clk);
    checkOutput({tag, " valid"}, 16'(out_valid), 16'd1);
    checkOutput({tag, " quot"}, 16'(out_quotient), 16'(expQ));
    checkOutput({tag, " sat"}, 16'(out_sat), 16'(expSat));
    checkOutput({tag, " div0"}, 16'(out_div0), 16'(expDiv0));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, " drained"}, 16'(level), 16'd0);
  endtask

  initial begin
    logic [OW-1:0] expHalfUp;
    logic [OW-1:0] expHalfDn;
    logic [OW-1:0] expEdge;
    logic          expEdgeSat;
    logic [OW-1:0] expNeg;

`ifdef LDIV_ROUND_EN
    expHalfUp  = 8'd4;
    expHalfDn  = 8'(-4);
    expEdge    = 8'd127;
    expEdgeSat = 1'b1;
    expNeg     = 8'(-6);
`else
    expHalfUp  = 8'd3;
    expHalfDn  = 8'(-3);
    expEdge    = 8'd127;
    expEdgeSat = 1'b0;
    expNeg     = 8'(-5);
`endif

    reset_n        = 1'b0;
    quotient_in    = '0;
    remainder_in   = '0;
    denominator_in = '0;
    valid_in       = 1'b0;
    out_ready      = 1'b0;

    #12;
    checkOutput("reset out_valid", 16'(out_valid), 16'd0);
    checkOutput("reset out_quotient", 16'(out_quotient), 16'd0);
    checkOutput("reset out_sat", 16'(out_sat), 16'd0);
    checkOutput("reset out_div0", 16'(out_div0), 16'd0);
    checkOutput("reset level", 16'(level), 16'd0);
    checkOutput("reset overflow", 16'(overflow), 16'd0);
    checkOutput("reset drop_count", drop_count, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] rounding, saturation and div0 vectors");
    checkVector("q3r1d2", 10'd3, 10'd1, 10'd2, expHalfUp, 1'b0, 1'b0);
    checkVector("qm3rm1d2", 10'(-3), 10'(-1), 10'd2, expHalfDn, 1'b0, 1'b0);
    checkVector("q3r1d4", 10'd3, 10'd1, 10'd4, 8'd3, 1'b0, 1'b0);
    checkVector("qm5rm4d7", 10'(-5), 10'(-4), 10'd7, expNeg, 1'b0, 1'b0);
    checkVector("q127r1d2", 10'd127, 10'd1, 10'd2, expEdge, expEdgeSat, 1'b0);
    checkVector("sat pos", 10'd200, 10'd0, 10'd5, 8'd127, 1'b1, 1'b0);
    checkVector("sat neg", 10'(-200), 10'd0, 10'd5, 8'h80, 1'b1, 1'b0);
    checkVector("div0 pos", 10'd9, 10'd5, 10'd0, 8'd127, 1'b1, 1'b1);
    checkVector("div0 neg", 10'd9, 10'(-5), 10'd0, 8'h80, 1'b1, 1'b1);

    $display("[TB] overflow with consumer stalled");
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(10'(i), 10'd0, 10'd1);
    end
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    checkOutput("ovf level", 16'(level), 16'd8);
    checkOutput("ovf drop_count", drop_count, 16'd2);
    checkOutput("ovf overflow", 16'(overflow), 16'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checkOutput($sformatf("ovf drain %0d", i), 16'(out_quotient), 16'(i));
      @(negedge clk);
    end
    out_ready = 1'b0;
    checkOutput("ovf empty", 16'(out_valid), 16'd0);
    checkOutput("ovf sticky", 16'(overflow), 16'd1);

    $display("[TB] full FIFO with simultaneous push and pop");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(10'(20 + i), 10'd0, 10'd1);
    end
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    checkOutput("full level", 16'(level), 16'd8);
    quotient_in = 10'd28;
    valid_in    = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      out_ready   = 1'b1;
      quotient_in = 10'(29 + k);
      checkOutput($sformatf("stream head %0d", k), 16'(out_quotient), 16'(20 + k));
      checkOutput($sformatf("stream level %0d", k), 16'(level), 16'd8);
    end
    @(negedge clk);
    valid_in = 1'b0;
    checkOutput("stream head 8", 16'(out_quotient), 16'd28);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("stream level end", 16'(level), 16'd8);
    checkOutput("stream no drops", drop_count, 16'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("stream drain %0d", i), 16'(out_quotient), 16'(29 + i));
      @(negedge clk);
    end
    out_ready = 1'b0;
    checkOutput("stream empty", 16'(level), 16'd0);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(10'(40 + i), 10'd0, 10'd1);
    end
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    checkOutput("pre-reset level", 16'(level), 16'd5);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("mid reset out_valid", 16'(out_valid), 16'd0);
    checkOutput("mid reset level", 16'(level), 16'd0);
    checkOutput("mid reset drop_count", drop_count, 16'd0);
    checkOutput("mid reset overflow", 16'(overflow), 16'd0);
    checkOutput("mid reset out_quotient", 16'(out_quotient), 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    checkVector("after reset", 10'd50, 10'd0, 10'd1, 8'd50, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/ldiv_round_buf.md
# ldiv_round_buf

Result post-processor and elastic buffer placed directly downstream of the pipelined long divider. Each cycle it accepts one divider result (quotient, remainder, denominator) and rounds the quotient to nearest, half away from zero. It then saturates the quotient to an output width and pushes it into a FIFO drained by a ready/valid consumer. The divider cannot stall, so the FIFO absorbs bursts and counts any results dropped on overflow.

## Interface
Parameters:
- NUMERATOR_WIDTH, 10, width of divider remainder (signed)
- DENOMINATOR_WIDTH, 10, width of divider denominator (unsigned)
- QUOTIENT_WIDTH, 10, width of divider quotient (signed)
- OUT_WIDTH, 8, width of saturated output quotient (signed), ≤ QUOTIENT_WIDTH
- DEPTH, 8, FIFO entries, power of two ≥ 2

Ports:
- clk  in  1  clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- quotient_in  in  QUOTIENT_WIDTH  signed truncated quotient from divider
- remainder_in  in  NUMERATOR_WIDTH  signed remainder; sign follows numerator
- denominator_in  in  DENOMINATOR_WIDTH  unsigned denominator
- valid_in  in  1  result valid; no backpressure
- out_quotient  out  OUT_WIDTH  signed rounded/saturated quotient at FIFO head
- out_sat  out  1  head entry was saturated
- out_div0  out  1  head entry had denominator 0
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head when out_valid & out_ready
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky; set on the first dropped result
- drop_count  out  16  dropped results, saturates at 16'hFFFF

## Operation
- Stage S1 registers on valid_in: rounded/saturated quotient, sat flag, div0 flag, s1_valid.
- Rounding: mag = |remainder_in| in max(NW,DW)+1 bits. If 2*mag ≥ denominator_in, q = quotient_in + (remainder_in < 0 ? -1 : +1); otherwise q = quotient_in. Computed in QUOTIENT_WIDTH+1 bits.
- Saturation: clamp q to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; set sat when clamped.
- Denominator 0: bypass rounding. Output max positive if remainder_in ≥ 0, else min negative. Set div0=1, sat=1.
- FIFO: stores {quotient, sat, div0} in DEPTH entries. Head is show-ahead, so outputs come combinationally from the read pointer. Pointers are $clog2(DEPTH)+1 bits; full/empty decode from the MSB compare.
- Push when s1_valid. Push is accepted if not full, or if full and a pop occurs in the same cycle.
- Otherwise the result is dropped: overflow←1, drop_count increments (saturating).
- Pop when out_valid & out_ready. A pop while empty is ignored.
- Simultaneous push and pop leaves level unchanged.

## Timing
- Reset (async assert, release sync to clk) clears s1_valid, pointers, level, overflow and drop_count. Outputs go to 0: out_valid=0, out_quotient=0, out_sat=0, out_div0=0.
- Reset mid-stream discards S1 and all FIFO contents immediately.
- Latency: valid_in sampled at edge N → S1 at N → FIFO write at N+1 → out_valid=1 after edge N+1 (2 cycles into an empty FIFO).
- Throughput: one push and one pop per cycle.
- level updates on the same edge as the push or pop.
- overflow and drop_count update on the edge at which the drop occurs.
- out_* must stay stable while out_valid & !out_ready.

## Configuration
- LDIV_ROUND_EN defined: rounding as above.
- LDIV_ROUND_EN undefined: q = quotient_in (truncation toward zero). The remainder compare logic is removed, and remainder_in is used only for the sign in the div0 case. Saturation, div0 handling and the FIFO are unchanged.

## Test plan
- Rounding: q=3, r=1, d=2 → out_quotient=4, sat=0. q=-3, r=-1, d=2 → -4. q=3, r=1, d=4 → 3. Without LDIV_ROUND_EN, q=3, r=1, d=2 → 3.
- Saturation (OUT_WIDTH=8): q=200, r=0, d=5 → 127, sat=1. q=-200 → -128, sat=1.
- Div0: d=0, r=5 → 127, div0=1, sat=1. d=0, r=-5 → -128, div0=1.
- Overflow: DEPTH=8, out_ready=0, 10 consecutive valid_in → level=8, drop_count=2, overflow=1. Then out_ready=1 drains the first 8 results in order.
- Full with push and pop together: FIFO full, out_ready=1, valid stream continues → no drops, level stays 8, order preserved.
- Reset mid-operation: FIFO at level 5, assert reset_n=0 between edges → out_valid=0, level=0, drop_count=0 immediately. The first valid_in after release appears 2 cycles later.
